// File: rtl/i2s_pcm1702_sequencer_if.sv
// I2S input / PCM1702 output bundle for i2s_pcm1702_sequencer.
//   lrck      word clock, low = left, high = right
//   datain    I2S serial data
//   dataoutl  left serial word to the DAC, MSB first
//   dataoutr  right serial word to the DAC, MSB first
//   leoutl    left latch-enable pulse
//   leoutr    right latch-enable pulse
//   locked    stream qualified, outputs unmuted
//   mute      inverse of locked
//   slot_len  last accepted slot length in BCK cycles
//   led1      lock LED, active low
// The slave modport is the sequencer; the master modport is the I2S source / observer.
interface i2s_pcm1702_sequencer_if;
  logic       lrck;
  logic       datain;
  logic       dataoutl;
  logic       dataoutr;
  logic       leoutl;
  logic       leoutr;
  logic       locked;
  logic       mute;
  logic [6:0] slot_len;
  logic       led1;

  modport master (
    output lrck, datain,
    input  dataoutl, dataoutr, leoutl, leoutr, locked, mute, slot_len, led1
  );

  modport slave (
    input  lrck, datain,
    output dataoutl, dataoutr, leoutl, leoutr, locked, mute, slot_len, led1
  );
endinterface

// File: rtl/i2s_pcm1702_sequencer.sv
// Frame controller for a dual-PCM1702 NOS DAC. Runs on BCK, measures the I2S slot
// length from LRCK edges, qualifies lock, captures the top WORD_BITS of each channel
// and replays both channels time-aligned in the following frame, each word followed
// by one latch-enable pulse. Words are forced to zero while the stream is not locked.
// Ports:
//   i_bck      bit clock, all logic on the rising edge
//   i_rst      synchronous reset, active high
//   o_bck_dac  BCK forwarded to the PCM1702 clock pins
//   bus        i2s_pcm1702_sequencer_if.slave (LRCK/DATAIN in, DAC pins and status out)
module i2s_pcm1702_sequencer #(
  parameter int unsigned WORD_BITS  = 20,
  parameter int unsigned LOCK_SLOTS = 8,
  parameter int unsigned CNT_MAX    = 127
) (
  input  logic                          i_bck,
  input  logic                          i_rst,
  output logic                          o_bck_dac,
  i2s_pcm1702_sequencer_if.slave        bus
);

  localparam int unsigned PosW = $clog2(CNT_MAX + 1);
  localparam int unsigned LenW = PosW + 1;
  localparam int unsigned CntW = $clog2(LOCK_SLOTS + 1);
  localparam int unsigned BitW = $clog2(WORD_BITS);

  typedef enum logic [1:0] {StUnlock, StAcq, StLock} state_e;

  state_e                r_state, w_state_d;
  logic [CntW-1:0]       r_good_cnt, w_good_cnt_d;
  logic [6:0]            r_slot_len, w_slot_len_d;
  logic                  r_locked;
  logic                  r_lrck_q;
  logic [PosW-1:0]       r_pos;
  logic [LenW-1:0]       r_prev_len;
  logic                  r_prev_valid;
  logic [WORD_BITS-1:0]  r_cap_l, r_cap_r, r_sh_l, r_sh_r;
  logic                  r_busy;
  logic [BitW-1:0]       r_bit;
  logic                  r_le;

  logic                  w_edge, w_fall, w_timeout, w_good, w_cap, w_enter_unlock;
  logic [PosW-1:0]       w_pos;
  logic [LenW-1:0]       w_len;

  assign w_edge = bus.lrck ^ r_lrck_q;
  assign w_fall = r_lrck_q & ~bus.lrck;
  // Position of the current cycle within the slot: 0 on the edge cycle, saturating.
  assign w_pos  = w_edge ? '0 : ((r_pos == PosW'(CNT_MAX)) ? r_pos : r_pos + PosW'(1));
  // An edge in the same cycle wins over the stopped-LRCK timeout.
  assign w_timeout = ~w_edge & (w_pos == PosW'(CNT_MAX));
  assign w_len  = LenW'(r_pos) + LenW'(1);
  assign w_good = w_edge & r_prev_valid & (w_len == r_prev_len) &
                  ((w_len == LenW'(24)) | (w_len == LenW'(32)));
  // Position 0 still carries the previous word's LSB.
  assign w_cap  = (w_pos != '0) && (w_pos <= PosW'(WORD_BITS));
  assign w_enter_unlock = (w_state_d == StUnlock) && (r_state != StUnlock);

  // Lock FSM next state.
  always_comb begin
    w_state_d    = r_state;
    w_good_cnt_d = r_good_cnt;
    w_slot_len_d = r_slot_len;
    case (r_state)
      StUnlock, StAcq: begin
        if (w_edge) begin
          if (w_good) begin
            w_good_cnt_d = r_good_cnt + CntW'(1);
            if (w_good_cnt_d == CntW'(LOCK_SLOTS)) begin
              w_state_d    = StLock;
              w_slot_len_d = 7'(w_len);
            end else begin
              w_state_d = StAcq;
            end
          end else begin
            w_state_d    = StUnlock;
            w_good_cnt_d = '0;
          end
        end else if (w_timeout) begin
          w_state_d    = StUnlock;
          w_good_cnt_d = '0;
        end
      end
      StLock: begin
        if ((w_edge & ~w_good) | w_timeout) begin
          w_state_d    = StUnlock;
          w_good_cnt_d = '0;
        end
      end
      default: begin
        w_state_d    = StUnlock;
        w_good_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_bck) begin
    if (i_rst) begin
      r_state    <= StUnlock;
      r_good_cnt <= '0;
      r_slot_len <= '0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_good_cnt <= w_good_cnt_d;
      r_slot_len <= w_slot_len_d;
      r_locked   <= (w_state_d == StLock);
    end
  end

  // Slot measurement. The first slot after reset or after dropping to UNLOCK only
  // sets the reference length.
  always_ff @(posedge i_bck) begin
    if (i_rst) begin
      r_lrck_q     <= 1'b0;
      r_pos        <= '0;
      r_prev_len   <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_lrck_q <= bus.lrck;
      r_pos    <= w_pos;
      if (w_edge) begin
        r_prev_len   <= w_len;
        r_prev_valid <= ~w_enter_unlock;
      end else if (w_timeout) begin
        r_prev_valid <= 1'b0;
      end
    end
  end

  // Capture and replay. Output shifters zero-fill so the pins idle low once the word
  // has left; a falling edge during a shift reloads and drops the pending LE.
  always_ff @(posedge i_bck) begin
    if (i_rst) begin
      r_cap_l <= '0;
      r_cap_r <= '0;
      r_sh_l  <= '0;
      r_sh_r  <= '0;
      r_busy  <= 1'b0;
      r_bit   <= '0;
      r_le    <= 1'b0;
    end else begin
      if (w_cap) begin
        if (bus.lrck) r_cap_r <= {r_cap_r[WORD_BITS-2:0], bus.datain};
        else          r_cap_l <= {r_cap_l[WORD_BITS-2:0], bus.datain};
      end
      r_le <= 1'b0;
      if (w_fall) begin
        r_sh_l <= (w_state_d == StLock) ? r_cap_l : '0;
        r_sh_r <= (w_state_d == StLock) ? r_cap_r : '0;
        r_busy <= 1'b1;
        r_bit  <= '0;
      end else if (r_busy) begin
        r_sh_l <= {r_sh_l[WORD_BITS-2:0], 1'b0};
        r_sh_r <= {r_sh_r[WORD_BITS-2:0], 1'b0};
        if (r_bit == BitW'(WORD_BITS - 1)) begin
          r_busy <= 1'b0;
          r_le   <= 1'b1;
        end else begin
          r_bit <= r_bit + BitW'(1);
        end
      end
    end
  end

  assign o_bck_dac    = i_bck;
  assign bus.dataoutl = r_sh_l[WORD_BITS-1];
  assign bus.dataoutr = r_sh_r[WORD_BITS-1];
  assign bus.leoutl   = r_le;
  assign bus.leoutr   = r_le;
  assign bus.locked   = r_locked;
  assign bus.mute     = ~r_locked;
  assign bus.led1     = ~r_locked;
  assign bus.slot_len = r_slot_len;

endmodule

// File: tb/tb_i2s_pcm1702_sequencer.sv
// Bench for i2s_pcm1702_sequencer: drives I2S frames, models slot qualification and
// lock, and scores the replayed words and LE timing against a queue of expected frames.
module tb_i2s_pcm1702_sequencer;
  localparam int WB        = 20;
  localparam int LockSlots = 8;

  typedef struct {
    int            e;
    logic [WB-1:0] l;
    logic [WB-1:0] r;
  } exp_t;

  logic clk;
  logic rst;
  logic bck_dac;
  int   cyc;
  int   n_checks;
  int   n_errors;

  i2s_pcm1702_sequencer_if bus_if ();

  i2s_pcm1702_sequencer #(
    .WORD_BITS (WB),
    .LOCK_SLOTS(LockSlots),
    .CNT_MAX   (127)
  ) dut (
    .i_bck    (clk),
    .i_rst    (rst),
    .o_bck_dac(bck_dac),
    .bus      (bus_if.slave)
  );

  // Reference model state.
  exp_t          sb_q[$];
  int            m_state;  // 0 unlock, 1 acq, 2 lock
  int            m_cnt;
  int            m_prev;
  int            m_since;
  int            m_slot_len;
  bit            m_valid;
  logic          m_lrck;
  logic [WB-1:0] m_cap_l;
  logic [WB-1:0] m_cap_r;
  logic [9:0]    exp_status;
  bit            st_valid;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_prev = 0; m_since = 1; m_slot_len = 0;
    m_valid = 0; m_lrck = 1'b0; m_cap_l = '0; m_cap_r = '0;
    sb_q.delete();
  endtask

  task automatic model_step(input logic l);
    int  len;
    int  prev_st;
    bit  good;
    exp_t x;
    if (l != m_lrck) begin
      len     = m_since;
      good    = m_valid && (len == m_prev) && (len == 24 || len == 32);
      prev_st = m_state;
      if (m_state == 2) begin
        if (!good) begin m_state = 0; m_cnt = 0; end
      end else if (good) begin
        m_cnt++;
        if (m_cnt == LockSlots) begin m_state = 2; m_slot_len = len; end
        else m_state = 1;
      end else begin
        m_state = 0; m_cnt = 0;
      end
      m_prev  = len;
      m_valid = !(m_state == 0 && prev_st != 0);
      m_since = 1;
      m_lrck  = l;
      if (l == 1'b0) begin
        x.e = cyc + 1;
        x.l = (m_state == 2) ? m_cap_l : '0;
        x.r = (m_state == 2) ? m_cap_r : '0;
        sb_q.push_back(x);
      end
    end else begin
      if (m_since < 128) m_since++;
      if (m_since == 128) begin m_state = 0; m_cnt = 0; m_valid = 0; end
    end
  endtask

  // One BCK cycle of stimulus; inputs change half a period before the sampling edge.
  task automatic drive_cycle(input logic l, input logic d, input logic r);
    logic lk;
    @(negedge clk);
    #1;
    if (st_valid)
      check_eq("status", 32'({bus_if.locked, bus_if.mute, bus_if.led1, bus_if.slot_len}),
               32'(exp_status));
    rst = r;
    bus_if.lrck = l;
    bus_if.datain = d;
    if (r) model_reset();
    else model_step(l);
    lk = (m_state == 2);
    exp_status = {lk, ~lk, ~lk, 7'(m_slot_len)};
    st_valid = 1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check_eq("rst_out", 32'({bus_if.dataoutl, bus_if.dataoutr, bus_if.leoutl, bus_if.leoutr}), 0);
    check_eq("rst_stat", 32'({bus_if.locked, bus_if.mute, bus_if.led1, bus_if.slot_len}),
             32'(10'b0110000000));
  endtask

  task automatic send_slot(input int len, input logic ch, input logic [WB-1:0] w, input int ncyc);
    logic d;
    for (int p = 0; p < ncyc; p++) begin
      if (p >= 1 && p <= WB) d = w[WB-p];
      else d = 1'($urandom_range(0, 1));
      drive_cycle(ch, d, 1'b0);
    end
    if (ncyc == len && len > WB) begin
      if (ch) m_cap_r = w;
      else m_cap_l = w;
    end
  endtask

  task automatic run_slots(input int n, input int len, input logic [WB-1:0] wl,
                           input logic [WB-1:0] wr);
    logic ch;
    for (int i = 0; i < n; i++) begin
      ch = ~m_lrck;
      send_slot(len, ch, ch ? wr : wl, len);
    end
  endtask

  // Output monitor: rebuilds serial words and scores them at each LE pulse.
  initial begin
    logic [WB-1:0] sh_l;
    logic [WB-1:0] sh_r;
    exp_t x;
    bit   in_win;
    sh_l = '0;
    sh_r = '0;
    forever begin
      @(negedge clk);
      in_win = (sb_q.size() > 0) && (cyc >= sb_q[0].e) && (cyc < sb_q[0].e + WB);
      if (!in_win && !rst)
        check_eq("idle_zero", 32'({bus_if.dataoutl, bus_if.dataoutr}), 0);
      if (bus_if.leoutl || bus_if.leoutr) begin
        check_eq("le_pair", 32'({bus_if.leoutl, bus_if.leoutr}), 32'h3);
        if (sb_q.size() == 0) begin
          check_eq("le_unexp", 32'(sb_q.size()), 1);
        end else begin
          x = sb_q.pop_front();
          check_eq("le_time", 32'(cyc), 32'(x.e + WB));
          check_eq("word_l", 32'(sh_l), 32'(x.l));
          check_eq("word_r", 32'(sh_r), 32'(x.r));
        end
      end
      sh_l = {sh_l[WB-2:0], bus_if.dataoutl};
      sh_r = {sh_r[WB-2:0], bus_if.dataoutr};
    end
  end

  initial begin
    cyc = 0; n_checks = 0; n_errors = 0; st_valid = 0;
    rst = 1'b1;
    bus_if.lrck = 1'b0;
    bus_if.datain = 1'b0;
    model_reset();

    // 32-bit slots, lock and replay.
    do_reset(3);
    @(negedge clk);
    check_eq("bck_fwd", 32'(bck_dac), 0);
    send_slot(3, 1'b0, '0, 3);
    run_slots(24, 32, 20'hA5A5A, 20'h3C3C3);
    check_eq("lock32", 32'(bus_if.locked), 1);
    check_eq("len32", 32'(bus_if.slot_len), 32);

    // Slot length change while locked, then relock at 24.
    run_slots(2, 24, 20'h12345, 20'h6789A);
    check_eq("chg_unlock", 32'(bus_if.locked), 0);
    check_eq("chg_len_held", 32'(bus_if.slot_len), 32);
    run_slots(12, 24, 20'h12345, 20'h6789A);
    check_eq("relock24", 32'(bus_if.locked), 1);
    check_eq("relen24", 32'(bus_if.slot_len), 24);

    // LRCK stopped low while locked.
    if (m_lrck == 1'b0) run_slots(1, 24, 20'h12345, 20'h6789A);
    send_slot(200, 1'b0, 20'h12345, 200);
    check_eq("timeout_unlock", 32'(bus_if.locked), 0);
    check_eq("timeout_led", 32'(bus_if.led1), 1);

    // 24-bit slots with extreme words.
    do_reset(3);
    send_slot(3, 1'b0, '0, 3);
    run_slots(24, 24, 20'h80000, 20'h7FFFF);
    check_eq("lock24", 32'(bus_if.locked), 1);
    check_eq("len24", 32'(bus_if.slot_len), 24);

    // Seven good slots then a 31-cycle slot.
    do_reset(3);
    send_slot(3, 1'b0, '0, 3);
    run_slots(8, 32, 20'hFFFFF, 20'h55555);
    send_slot(31, ~m_lrck, 20'hFFFFF, 31);
    run_slots(3, 32, 20'hFFFFF, 20'h55555);
    check_eq("acq_locked", 32'(bus_if.locked), 0);
    check_eq("acq_mute", 32'(bus_if.mute), 1);
    check_eq("acq_led", 32'(bus_if.led1), 1);

    // Reset at slot position 10 of a shifting word.
    do_reset(3);
    send_slot(3, 1'b0, '0, 3);
    run_slots(24, 32, 20'hC0FFE, 20'h0BEEF);
    if (m_lrck == 1'b0) run_slots(1, 32, 20'hC0FFE, 20'h0BEEF);
    send_slot(32, 1'b0, 20'hC0FFE, 10);
    do_reset(2);
    send_slot(40, 1'b0, '0, 40);

    check_eq("sb_empty", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
